register_q_shift: RTL and testbench
===================================

Name: register_q_shift

Overview:
- Parametrised quotient register for the iterative divider datapath. Generalises the plain load register.
- Supports parallel load, synchronous clear, and left-shift with serial insert of the quotient bit.
- Has an internal shift counter that flags completion after WIDTH shifts.
- The divider controller drives it once per iteration and uses the done flag to terminate the division.

Parameters:
- WIDTH, 16, register width in bits (legal range 2..64).
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; not overridden by users).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous clear of the register and the counter.
- ld_register  input  1  parallel load of input_data.
- shift_en  input  1  shift left by one and insert serial_in at bit 0.
- serial_in  input  1  quotient bit inserted at the LSB on a shift.
- input_data  input  WIDTH  parallel load value.
- output_data  output  WIDTH  register contents.
- shift_out  output  1  registered copy of the MSB shifted out by the most recent accepted shift.
- shift_count  output  CNT_W  number of accepted shifts since the last load, clear or reset.
- count_done  output  1  high when shift_count == WIDTH.

Behaviour:
- All state updates on the rising edge of clk. There is no asynchronous path.
- Reset values (rst high at an edge): output_data = 0, shift_out = 0, shift_count = 0, count_done = 0.
- Priority per edge: rst > clr > ld_register > shift_en > hold.
- clr:
  - output_data = 0, shift_count = 0, shift_out = 0.
  - Overrides ld_register and shift_en asserted in the same cycle.
- ld_register (clr low):
  - output_data = input_data, shift_count = 0, shift_out unchanged.
  - A simultaneous shift_en is ignored.
- shift_en (clr and ld_register low, count_done low):
  - output_data = {output_data[WIDTH-2:0], serial_in}.
  - shift_out = old output_data[WIDTH-1].
  - shift_count increments by 1.
- shift_en while count_done is high:
  - The shift is rejected. output_data, shift_out and shift_count hold.
  - shift_count saturates at WIDTH and never wraps.
- Hold: when no control is active, all state is retained.
- count_done:
  - Combinational compare of the registered shift_count, so it is glitch-free relative to clk.
  - Rises in the cycle after the WIDTH-th accepted shift.
  - Deasserts in the cycle after a load, clear or reset.
- Latency: every change is visible on the outputs one cycle after the controlling edge. There is no combinational path from any input to any output.
- Reset mid-operation: a partial shift sequence is discarded. The counter returns to 0 and the next division starts with ld_register or clr.
- Unknown or X on shift_en or ld_register while rst is high has no effect.

Test Plan:
- Reset: drive rst for 2 cycles with ld_register = 1 and input_data = 16'hBEEF -> after release, output_data = 0, shift_count = 0, count_done = 0.
- Load then shift: load 16'h8001, then shift_en with serial_in = 1 -> output_data = 16'h0003, shift_out = 1, shift_count = 1.
- Full sequence: clr, then 16 shifts with serial_in pattern 1010...10 -> output_data = 16'hAAAA, count_done rises exactly after the 16th shift. A 17th shift_en is rejected, so output_data stays 16'hAAAA and shift_count stays 16.
- Priority: in one cycle assert clr, ld_register (input_data = 16'h1234) and shift_en -> output_data = 0, shift_count = 0. Next cycle assert ld_register = 1 and shift_en = 1 with input_data = 16'h1234 -> output_data = 16'h1234, shift_count = 0.
- Mid-sequence reset: after 7 shifts, pulse rst for 1 cycle -> output_data = 0, shift_count = 0. Then 16 further shifts reach count_done.
- Parameter sweep: WIDTH = 8 -> count_done after 8 shifts, CNT_W = 4. Loading 8'hFF followed by one shift with serial_in = 0 -> 8'hFE, shift_out = 1.

Source files
------------

// File: rtl/register_q_shift.sv
// Quotient register for the iterative divider: parallel load, clear, and
// left-shift with serial quotient-bit insert, plus a saturating shift counter.
module register_q_shift #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld_register,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] input_data,
  output logic [WIDTH-1:0] output_data,
  output logic             shift_out,
  output logic [CNT_W-1:0] shift_count,
  output logic             count_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  // Priority: rst > clr > ld_register > shift_en > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      output_data <= '0;
      shift_out   <= 1'b0;
      shift_count <= '0;
    end else if (clr) begin
      output_data <= '0;
      shift_out   <= 1'b0;
      shift_count <= '0;
    end else if (ld_register) begin
      output_data <= input_data;
      shift_count <= '0;
    end else if (shift_en && !count_done) begin
      output_data <= {output_data[WIDTH-2:0], serial_in};
      shift_out   <= output_data[WIDTH-1];
      shift_count <= shift_count + CNT_W'(1);
    end
  end

  // Decoded from the registered count only, so it never sees input glitches
  assign count_done = (shift_count == CNT_MAX);

endmodule

// File: tb/tb_register_q_shift.sv
// Scoreboard bench for register_q_shift: WIDTH=16 and WIDTH=8 instances
// driven on negedge, expectations queued, monitor compares after each posedge.
module tb_register_q_shift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, clr16, ld16, sh16, si16;
  logic [15:0] din16, q16;
  logic        so16, done16;
  logic [4:0]  cnt16;

  logic        rst8, clr8, ld8, sh8, si8;
  logic [7:0]  din8, q8;
  logic        so8, done8;
  logic [3:0]  cnt8;

  register_q_shift #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst16), .clr(clr16), .ld_register(ld16), .shift_en(sh16),
    .serial_in(si16), .input_data(din16), .output_data(q16), .shift_out(so16),
    .shift_count(cnt16), .count_done(done16)
  );

  register_q_shift #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .clr(clr8), .ld_register(ld8), .shift_en(sh8),
    .serial_in(si8), .input_data(din8), .output_data(q8), .shift_out(so8),
    .shift_count(cnt8), .count_done(done8)
  );

  typedef struct {
    logic [63:0] q;
    logic        so;
    int          cnt;
    logic        done;
    string       name;
  } exp_t;

  exp_t sb16[$];
  exp_t sb8[$];

  int tests = 0;
  int fails = 0;

  // Reference state, one set per instance
  logic [63:0] m16_q = '0, m8_q = '0;
  logic        m16_so = 1'b0, m8_so = 1'b0;
  int          m16_cnt = 0, m8_cnt = 0;

  task automatic model_step(input int w, input logic r, c, l, s, si,
                            input logic [63:0] din,
                            input logic [63:0] qi, input logic soi, input int ci,
                            output logic [63:0] qo, output logic soo, output int co);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    qo = qi; soo = soi; co = ci;
    if (r) begin
      qo = '0; soo = 1'b0; co = 0;
    end else if (c) begin
      qo = '0; soo = 1'b0; co = 0;
    end else if (l) begin
      qo = din & mask; co = 0;
    end else if (s && ci != w) begin
      soo = qi[w-1];
      qo  = ((qi << 1) | {63'd0, si}) & mask;
      co  = ci + 1;
    end
  endtask

  // One clock of stimulus on the selected instance; the other sees only rst.
  task automatic step(input bit sel8, input logic r, c, l, s, si,
                      input logic [63:0] din, input string name);
    exp_t e;
    logic [63:0] nq;
    logic nso;
    int ncnt;
    @(negedge clk);
    rst16 = r; rst8 = r;
    if (!sel8) begin
      clr16 = c; ld16 = l; sh16 = s; si16 = si; din16 = din[15:0];
      clr8 = 0; ld8 = 0; sh8 = 0; si8 = 0; din8 = '0;
      model_step(16, r, c, l, s, si, din, m16_q, m16_so, m16_cnt, nq, nso, ncnt);
      m16_q = nq; m16_so = nso; m16_cnt = ncnt;
      model_step(8, r, 0, 0, 0, 0, '0, m8_q, m8_so, m8_cnt, nq, nso, ncnt);
      m8_q = nq; m8_so = nso; m8_cnt = ncnt;
    end else begin
      clr8 = c; ld8 = l; sh8 = s; si8 = si; din8 = din[7:0];
      clr16 = 0; ld16 = 0; sh16 = 0; si16 = 0; din16 = '0;
      model_step(8, r, c, l, s, si, din, m8_q, m8_so, m8_cnt, nq, nso, ncnt);
      m8_q = nq; m8_so = nso; m8_cnt = ncnt;
      model_step(16, r, 0, 0, 0, 0, '0, m16_q, m16_so, m16_cnt, nq, nso, ncnt);
      m16_q = nq; m16_so = nso; m16_cnt = ncnt;
    end
    e.q = m16_q; e.so = m16_so; e.cnt = m16_cnt; e.done = (m16_cnt == 16);
    e.name = sel8 ? {"w16_idle/", name} : {"w16/", name};
    sb16.push_back(e);
    e.q = m8_q; e.so = m8_so; e.cnt = m8_cnt; e.done = (m8_cnt == 8);
    e.name = sel8 ? {"w8/", name} : {"w8_idle/", name};
    sb8.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is checked for both widths
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb16.size() > 0) begin
        e = sb16.pop_front();
        tests++;
        if (q16 !== e.q[15:0] || so16 !== e.so || cnt16 !== 5'(e.cnt) || done16 !== e.done) begin
          fails++;
          $display("FAIL %s: got q=%h so=%b cnt=%0d done=%b, want q=%h so=%b cnt=%0d done=%b",
                   e.name, q16, so16, cnt16, done16, e.q[15:0], e.so, e.cnt, e.done);
        end
      end
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        tests++;
        if (q8 !== e.q[7:0] || so8 !== e.so || cnt8 !== 4'(e.cnt) || done8 !== e.done) begin
          fails++;
          $display("FAIL %s: got q=%h so=%b cnt=%0d done=%b, want q=%h so=%b cnt=%0d done=%b",
                   e.name, q8, so8, cnt8, done8, e.q[7:0], e.so, e.cnt, e.done);
        end
      end
    end
  end

  initial begin
    rst16 = 1; clr16 = 0; ld16 = 0; sh16 = 0; si16 = 0; din16 = '0;
    rst8  = 1; clr8  = 0; ld8  = 0; sh8  = 0; si8  = 0; din8  = '0;

    // Reset dominates a concurrent load
    step(0, 1, 0, 1, 0, 0, 64'hBEEF, "reset_with_load0");
    step(0, 1, 0, 1, 0, 0, 64'hBEEF, "reset_with_load1");
    step(0, 0, 0, 0, 0, 0, '0, "post_reset_hold");

    // Load then shift: 8001 -> 0003, MSB out
    step(0, 0, 0, 1, 0, 0, 64'h8001, "load_8001");
    step(0, 0, 0, 0, 1, 1, '0, "shift_after_load");

    // Full sequence 1010..10 -> AAAA, then a rejected 17th shift
    step(0, 0, 1, 0, 0, 0, '0, "clr_before_full");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, logic'(i % 2 == 0), '0, "full_shift");
    step(0, 0, 0, 0, 1, 1, '0, "shift_rejected_17");
    step(0, 0, 0, 0, 1, 0, '0, "shift_rejected_18");
    step(0, 0, 0, 0, 0, 0, '0, "hold_done");

    // Priority: clr beats load+shift, load beats shift
    step(0, 0, 1, 1, 1, 1, 64'h1234, "clr_ld_sh");
    step(0, 0, 0, 1, 1, 1, 64'h1234, "ld_sh");
    step(0, 0, 0, 0, 0, 0, '0, "hold_1234");

    // Mid-sequence reset with X on controls, then a fresh full run
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, logic'(i % 3 == 0), '0, "partial_shift");
    step(0, 1, 0, 1'bx, 1'bx, 0, 64'hFFFF, "mid_reset_x");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, logic'((i * 5) % 7 > 2), '0, "post_reset_shift");
    step(0, 0, 0, 0, 1, 1, '0, "post_reset_rejected");
    step(0, 0, 0, 1, 0, 0, 64'h00F0, "reload_clears_done");

    // WIDTH=8: FF shifted with 0 -> FE, then saturate at 8
    step(1, 0, 0, 1, 0, 0, 64'hFF, "load_ff");
    step(1, 0, 0, 0, 1, 0, '0, "shift_fe");
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1, logic'(i % 2), '0, "w8_shift");
    step(1, 0, 0, 0, 1, 1, '0, "w8_rejected");
    step(1, 0, 1, 0, 0, 0, '0, "w8_clr");

    // Drain the scoreboard within a fixed budget
    repeat (3) @(negedge clk);
    tests++;
    if (sb16.size() != 0 || sb8.size() != 0) begin
      fails++;
      $display("FAIL drain: pending16=%0d pending8=%0d, want 0 and 0", sb16.size(), sb8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
